// File: rtl/rf_pkg.sv
// Shared widths, x0 index and FSM state encoding for the register-file
// operand-fetch block.
package rf_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] X0_IDX = '0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID
  } state_e;

endpackage

// File: rtl/rf_bypass_mux.sv
// Per-operand select: x0 always reads as zero, otherwise the registered
// write data wins over RF read data on an index match.
module rf_bypass_mux
  import rf_pkg::*;
(
  input  logic [AW-1:0]   idx,
  input  logic [XLEN-1:0] rf_data,
  input  logic            byp_we,
  input  logic [AW-1:0]   byp_idx,
  input  logic [XLEN-1:0] byp_data,
  output logic [XLEN-1:0] op
);

  always_comb begin
    op = rf_data;
    if (idx == X0_IDX) begin
      op = '0;
    end else if (byp_we && (byp_idx == idx)) begin
      op = byp_data;
    end
  end

endmodule

// File: rtl/rf_operand_fetch.sv
// Register-file read initiator with write-port driver and completion check.
// Optional macro RF_BYPASS_EN: forward accept-cycle writes instead of stalling.
module rf_operand_fetch
  import rf_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_rd_we,
  output logic [AW-1:0]   rf_read_reg1,
  output logic [AW-1:0]   rf_read_reg2,
  input  logic [XLEN-1:0] rf_read_data1,
  input  logic [XLEN-1:0] rf_read_data2,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            rf_write_enable,
  output logic [AW-1:0]   rf_write_reg,
  output logic [XLEN-1:0] rf_write_data,
  input  logic            rf_write_done,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [AW-1:0]   out_rd,
  output logic            out_rd_we,
  output logic            err_wb
);

  state_e          state_q, state_d;
  logic [AW-1:0]   rs1_q, rs2_q;
  logic [AW-1:0]   out_rd_q;
  logic            out_rd_we_q;
  logic [XLEN-1:0] op1_q, op2_q;
  logic [XLEN-1:0] op1_d, op2_d;
  logic            pending_q, err_wb_q;
  logic            take_new, hazard, accept;
  logic            byp_we;
  logic [AW-1:0]   byp_idx;
  logic [XLEN-1:0] byp_data;

  assign rf_write_enable = wb_valid && (wb_rd != X0_IDX);
  assign rf_write_reg    = wb_rd;
  assign rf_write_data   = wb_data;

`ifdef RF_BYPASS_EN
  logic            byp_we_q;
  logic [AW-1:0]   byp_idx_q;
  logic [XLEN-1:0] byp_data_q;

  assign hazard   = 1'b0;
  assign byp_we   = byp_we_q;
  assign byp_idx  = byp_idx_q;
  assign byp_data = byp_data_q;

  // Snapshot the write issued alongside the accept; the RF misses it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_we_q   <= 1'b0;
      byp_idx_q  <= '0;
      byp_data_q <= '0;
    end else if (accept) begin
      byp_we_q   <= rf_write_enable;
      byp_idx_q  <= rf_write_reg;
      byp_data_q <= rf_write_data;
    end
  end
`else
  assign hazard   = rf_write_enable &&
                    (((in_rs1 != X0_IDX) && (in_rs1 == wb_rd)) ||
                     ((in_rs2 != X0_IDX) && (in_rs2 == wb_rd)));
  assign byp_we   = 1'b0;
  assign byp_idx  = '0;
  assign byp_data = '0;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    take_new     = (state_q == IDLE) || ((state_q == VALID) && out_ready);
    in_ready     = take_new && !hazard;
    accept       = in_valid && in_ready;
    rf_read_reg1 = take_new ? in_rs1 : rs1_q;
    rf_read_reg2 = take_new ? in_rs2 : rs2_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = FETCH;
      FETCH:   state_d = VALID;
      VALID:   if (out_ready) state_d = accept ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  rf_bypass_mux u_mux1 (
    .idx      (rs1_q),
    .rf_data  (rf_read_data1),
    .byp_we   (byp_we),
    .byp_idx  (byp_idx),
    .byp_data (byp_data),
    .op       (op1_d)
  );

  rf_bypass_mux u_mux2 (
    .idx      (rs2_q),
    .rf_data  (rf_read_data2),
    .byp_we   (byp_we),
    .byp_idx  (byp_idx),
    .byp_data (byp_data),
    .op       (op2_d)
  );

  // NOTE: state uses non-blocking assignments with an asynchronous reset so
  // every flop updates from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      out_rd_q    <= '0;
      out_rd_we_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      pending_q   <= 1'b0;
      err_wb_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= rf_write_enable;
      if (pending_q != rf_write_done) err_wb_q <= 1'b1;
      if (accept) begin
        rs1_q       <= in_rs1;
        rs2_q       <= in_rs2;
        out_rd_q    <= in_rd;
        out_rd_we_q <= in_rd_we;
      end
      if (state_q == FETCH) begin
        op1_q <= op1_d;
        op2_q <= op2_d;
      end
    end
  end

  assign out_valid = (state_q == VALID);
  assign out_op1   = op1_q;
  assign out_op2   = op2_q;
  assign out_rd    = out_rd_q;
  assign out_rd_we = out_rd_we_q;
  assign err_wb    = err_wb_q;

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Directed bench for rf_operand_fetch with a registered-read RF model and a
// controllable write-completion pulse.
module tb_rf_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_we;
  logic [4:0]  rf_read_reg1, rf_read_reg2;
  logic [31:0] rf_read_data1 = '0, rf_read_data2 = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        rf_write_enable;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        rf_write_done;
  logic        out_valid, out_ready;
  logic [31:0] out_op1, out_op2;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        err_wb;

  int n_cmp = 0;
  int n_bad = 0;

  // x0 holds garbage on purpose: the block must still return zero for it.
  logic [31:0] rf_mem [32] = '{0: 32'hDEAD_BEEF, default: 32'h0};
  logic        done_r = 1'b0;
  logic        suppress_done, inject_done;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rf_read_data1 <= rf_mem[rf_read_reg1];
    rf_read_data2 <= rf_mem[rf_read_reg2];
    if (rf_write_enable) rf_mem[rf_write_reg] <= rf_write_data;
    done_r <= rf_write_enable && !suppress_done;
  end
  assign rf_write_done = done_r | inject_done;

  rf_operand_fetch dut (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (in_ready),
    .in_rs1 (in_rs1), .in_rs2 (in_rs2), .in_rd (in_rd), .in_rd_we (in_rd_we),
    .rf_read_reg1 (rf_read_reg1), .rf_read_reg2 (rf_read_reg2),
    .rf_read_data1 (rf_read_data1), .rf_read_data2 (rf_read_data2),
    .wb_valid (wb_valid), .wb_rd (wb_rd), .wb_data (wb_data),
    .rf_write_enable (rf_write_enable), .rf_write_reg (rf_write_reg),
    .rf_write_data (rf_write_data), .rf_write_done (rf_write_done),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_op1 (out_op1), .out_op2 (out_op2),
    .out_rd (out_rd), .out_rd_we (out_rd_we),
    .err_wb (err_wb)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we);
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_we = we;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_we = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0; out_ready = 0;
    suppress_done = 0; inject_done = 0;
    step(); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_op1 !== 32'h0 || out_op2 !== 32'h0) begin n_bad++; $display("FAIL reset_ops got %h/%h want 0/0", out_op1, out_op2); end
    n_cmp++; if (out_rd !== 5'd0 || out_rd_we !== 1'b0) begin n_bad++; $display("FAIL reset_rd got %0d/%b want 0/0", out_rd, out_rd_we); end
    n_cmp++; if (err_wb !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err_wb); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_fetch();
    wb_valid = 1; wb_rd = 5'd5; wb_data = 32'h1234;
    #1;
    n_cmp++; if (rf_write_enable !== 1'b1) begin n_bad++; $display("FAIL seed_we got %b want 1", rf_write_enable); end
    step();
    wb_valid = 0;
    request(5'd5, 5'd0, 5'd3, 1'b1);
    #1;
    n_cmp++; if (in_ready !== 1'b1 || rf_read_reg1 !== 5'd5) begin n_bad++; $display("FAIL idle_addr got rdy=%b a1=%0d want 1/5", in_ready, rf_read_reg1); end
    step();
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL fetch_state got v=%b rdy=%b want 0/0", out_valid, in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL latency got %b want 1", out_valid); end
    n_cmp++; if (out_op1 !== 32'h1234 || out_op2 !== 32'h0) begin n_bad++; $display("FAIL basic_ops got %h/%h want 1234/0", out_op1, out_op2); end
    n_cmp++; if (out_rd !== 5'd3 || out_rd_we !== 1'b1) begin n_bad++; $display("FAIL basic_rd got %0d/%b want 3/1", out_rd, out_rd_we); end
    out_ready = 1;
    step();
    out_ready = 0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL handshake_drop got %b want 0", out_valid); end
    n_cmp++; if (err_wb !== 1'b0) begin n_bad++; $display("FAIL basic_err got %b want 0", err_wb); end
  endtask

  task automatic test_hazard();
    wb_valid = 1; wb_rd = 5'd7; wb_data = 32'hA5A5;
    request(5'd7, 5'd5, 5'd1, 1'b0);
    #1;
`ifdef RF_BYPASS_EN
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL hazard_nostall got %b want 1", in_ready); end
    step();
    wb_valid = 0; in_valid = 0;
`else
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hazard_stall got %b want 0", in_ready); end
    step();
    wb_valid = 0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL hazard_release got %b want 1", in_ready); end
    step();
    in_valid = 0;
`endif
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hazard_valid got %b want 1", out_valid); end
    n_cmp++; if (out_op1 !== 32'hA5A5 || out_op2 !== 32'h1234) begin n_bad++; $display("FAIL hazard_ops got %h/%h want a5a5/1234", out_op1, out_op2); end
    out_ready = 1;
    step();
    out_ready = 0;
  endtask

  task automatic test_back_to_back();
    request(5'd5, 5'd7, 5'd2, 1'b1);
    step();
    in_valid = 0;
    step();
    request(5'd0, 5'd5, 5'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_hs[%0d] got v=%b rdy=%b want 1/0", i, out_valid, in_ready); end
      n_cmp++; if (out_op1 !== 32'h1234 || out_op2 !== 32'hA5A5) begin n_bad++; $display("FAIL hold_ops[%0d] got %h/%h want 1234/a5a5", i, out_op1, out_op2); end
      step();
    end
    out_ready = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || rf_read_reg2 !== 5'd5) begin n_bad++; $display("FAIL b2b_accept got rdy=%b a2=%0d want 1/5", in_ready, rf_read_reg2); end
    step();
    out_ready = 0; in_valid = 0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_fetch got %b want 0", out_valid); end
    step();
    n_cmp++; if (out_op1 !== 32'h0 || out_op2 !== 32'h1234 || out_rd !== 5'd4) begin n_bad++; $display("FAIL b2b_ops got %h/%h rd=%0d want 0/1234 rd=4", out_op1, out_op2, out_rd); end
    out_ready = 1;
    step();
    out_ready = 0;
  endtask

  task automatic test_x0_write();
    wb_valid = 1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if (rf_write_enable !== 1'b0) begin n_bad++; $display("FAIL x0_we got %b want 0", rf_write_enable); end
    step();
    wb_valid = 0;
    request(5'd0, 5'd0, 5'd0, 1'b0);
    step();
    in_valid = 0;
    step();
    n_cmp++; if (out_op1 !== 32'h0 || out_op2 !== 32'h0) begin n_bad++; $display("FAIL x0_read got %h/%h want 0/0", out_op1, out_op2); end
    n_cmp++; if (err_wb !== 1'b0) begin n_bad++; $display("FAIL x0_err got %b want 0", err_wb); end
    out_ready = 1;
    step();
    out_ready = 0;
  endtask

  task automatic test_write_check();
    wb_valid = 1; wb_rd = 5'd9; wb_data = 32'h99; suppress_done = 1;
    step();
    wb_valid = 0;
    n_cmp++; if (err_wb !== 1'b0) begin n_bad++; $display("FAIL missing_early got %b want 0", err_wb); end
    step();
    suppress_done = 0;
    n_cmp++; if (err_wb !== 1'b1) begin n_bad++; $display("FAIL missing_done got %b want 1", err_wb); end
    step(); step(); step();
    n_cmp++; if (err_wb !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", err_wb); end
    rst = 1; #1; rst = 0;
    n_cmp++; if (err_wb !== 1'b0) begin n_bad++; $display("FAIL err_clear got %b want 0", err_wb); end
    step();
    inject_done = 1;
    step();
    inject_done = 0;
    n_cmp++; if (err_wb !== 1'b1) begin n_bad++; $display("FAIL spurious_done got %b want 1", err_wb); end
  endtask

  task automatic test_reset_in_fetch();
    request(5'd5, 5'd7, 5'd6, 1'b1);
    step();
    in_valid = 0;
    rst = 1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_fetch got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    n_cmp++; if (err_wb !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", err_wb); end
    step();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0 || out_op1 !== 32'h0) begin n_bad++; $display("FAIL rst_drop[%0d] got v=%b op1=%h want 0/0", i, out_valid, out_op1); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_hazard();
    test_back_to_back();
    test_x0_write();
    test_write_check();
    test_reset_in_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
